// File: rtl/ntp_poll_scheduler.sv
// NTP poll scheduler: paces client requests, supervises the send and the
// server reply, retries with backoff on timeout and reports sync health.
module ntp_poll_scheduler #(
   parameter int unsigned POLL_CYC    = 125_000_000,
   parameter int unsigned SEND_TO_CYC = 12_500,
   parameter int unsigned RESP_TO_CYC = 12_500_000,
   parameter int unsigned GAP_CYC     = 1_250_000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_connect_state,
   input  logic        i_force_sync,
   input  logic        i_cmd_end,
   input  logic        i_ntp_set_sig,
   output logic        o_ntp_sig,
   output logic        o_busy,
   output logic        o_sync_ok,
   output logic        o_sync_fail,
   output logic [3:0]  o_retry_cnt,
   output logic [15:0] o_sync_cnt,
   output logic [15:0] o_fail_cnt,
   output logic [2:0]  o_state
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StReq      = 3'd1,
      StWaitSend = 3'd2,
      StWaitResp = 3'd3,
      StBackoff  = 3'd4,
      StPeriod   = 3'd5
   } state_e;

   // A wait of N cycles expires in the cycle where the timer reads N-1.
   localparam logic [31:0] SendLast = 32'(SEND_TO_CYC - 1);
   localparam logic [31:0] RespLast = 32'(RESP_TO_CYC - 1);
   localparam logic [31:0] GapLast  = 32'(GAP_CYC - 1);
   localparam logic [31:0] PollLast = 32'(POLL_CYC - 1);
   localparam logic [3:0]  MaxRetry = 4'(MAX_RETRY);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [31:0] r_timer;
   logic        r_sync_ok;
   logic        w_sync_ok_nxt;
   logic        r_sync_fail;
   logic        w_sync_fail_nxt;
   logic [3:0]  r_retry_cnt;
   logic [3:0]  w_retry_nxt;
   logic [3:0]  w_retry_inc;
   logic [15:0] r_sync_cnt;
   logic [15:0] w_sync_cnt_nxt;
   logic [15:0] r_fail_cnt;
   logic [15:0] w_fail_cnt_nxt;
   logic        r_ntp_sig;
   logic        r_busy;
   logic        w_run;
   logic        w_timeout;

   assign w_run       = i_enable & i_connect_state;
   assign w_retry_inc = r_retry_cnt + 4'd1;

   // Next-state and status update; abort is applied last so it overrides all.
   always_comb begin
      w_state_nxt     = r_state;
      w_sync_ok_nxt   = r_sync_ok;
      w_sync_fail_nxt = r_sync_fail;
      w_retry_nxt     = r_retry_cnt;
      w_sync_cnt_nxt  = r_sync_cnt;
      w_fail_cnt_nxt  = r_fail_cnt;
      w_timeout       = 1'b0;

      case (r_state)
         StIdle: begin
            if (w_run) w_state_nxt = StReq;
            if (!i_connect_state) w_sync_ok_nxt = 1'b0;
         end
         StReq: w_state_nxt = StWaitSend;
         StWaitSend: begin
            // A send completion coincident with expiry still counts as sent.
            if (i_cmd_end) w_state_nxt = StWaitResp;
            else if (r_timer == SendLast) w_timeout = 1'b1;
         end
         StWaitResp: begin
            if (i_ntp_set_sig) begin
               w_state_nxt     = StPeriod;
               w_sync_ok_nxt   = 1'b1;
               w_sync_fail_nxt = 1'b0;
               w_retry_nxt     = 4'd0;
               w_sync_cnt_nxt  = r_sync_cnt + 16'd1;
            end else if (r_timer == RespLast) begin
               w_timeout = 1'b1;
            end
         end
         StBackoff: if (r_timer == GapLast) w_state_nxt = StReq;
         StPeriod:  if (i_force_sync || (r_timer == PollLast)) w_state_nxt = StReq;
         default:   w_state_nxt = StIdle;
      endcase

      if (w_timeout) begin
         if (w_retry_inc < MaxRetry) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = StBackoff;
         end else begin
            w_sync_ok_nxt   = 1'b0;
            w_sync_fail_nxt = 1'b1;
            w_fail_cnt_nxt  = r_fail_cnt + 16'd1;
            w_retry_nxt     = 4'd0;
            w_state_nxt     = StPeriod;
         end
      end

      if ((r_state != StIdle) && !w_run) begin
         w_state_nxt     = StIdle;
         w_sync_ok_nxt   = 1'b0;
         w_retry_nxt     = 4'd0;
         w_sync_fail_nxt = r_sync_fail;
         w_sync_cnt_nxt  = r_sync_cnt;
         w_fail_cnt_nxt  = r_fail_cnt;
      end
   end

   // State, timer and registered outputs; the timer restarts on every state entry.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_timer     <= 32'd0;
         r_sync_ok   <= 1'b0;
         r_sync_fail <= 1'b0;
         r_retry_cnt <= 4'd0;
         r_sync_cnt  <= 16'd0;
         r_fail_cnt  <= 16'd0;
         r_ntp_sig   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_timer     <= (w_state_nxt != r_state) ? 32'd0 : r_timer + 32'd1;
         r_sync_ok   <= w_sync_ok_nxt;
         r_sync_fail <= w_sync_fail_nxt;
         r_retry_cnt <= w_retry_nxt;
         r_sync_cnt  <= w_sync_cnt_nxt;
         r_fail_cnt  <= w_fail_cnt_nxt;
         r_ntp_sig   <= (w_state_nxt == StReq);
         r_busy      <= (w_state_nxt inside {StReq, StWaitSend, StWaitResp, StBackoff});
      end
   end

   assign o_ntp_sig   = r_ntp_sig;
   assign o_busy      = r_busy;
   assign o_sync_ok   = r_sync_ok;
   assign o_sync_fail = r_sync_fail;
   assign o_retry_cnt = r_retry_cnt;
   assign o_sync_cnt  = r_sync_cnt;
   assign o_fail_cnt  = r_fail_cnt;
   assign o_state     = r_state;

endmodule
